// File: rtl/fir_s2p_buffer_pkg.sv
// fir_s2p_buffer_pkg: shared DSP chain defaults (block size, sample width, frame length) and derived widths
package fir_s2p_buffer_pkg;
  localparam int N_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int BLOCKS_DEF = 64;
  localparam int IW_DEF = $clog2(N_DEF);
  localparam int BW_DEF = $clog2(BLOCKS_DEF);
endpackage

// File: rtl/fir_s2p_buffer_if.sv
// fir_s2p_buffer_if: FIR sample stream in, parallel block handshake out, status flags
interface fir_s2p_buffer_if import fir_s2p_buffer_pkg::*; #(parameter int N = N_DEF, parameter int DW = DW_DEF);
  logic [DW-1:0] fir_d;
  logic fir_valid;
  logic [N*DW-1:0] blk_d;
  logic blk_valid;
  logic blk_ready;
  logic frame_done;
  logic overflow;
  modport master(output fir_d, fir_valid, blk_ready, input blk_d, blk_valid, frame_done, overflow);
  modport slave(input fir_d, fir_valid, blk_ready, output blk_d, blk_valid, frame_done, overflow);
endinterface

// File: rtl/fir_s2p_buffer_bank.sv
// s2p_bank: N x DW register file with indexed write and the whole bank exposed as a flat read bus
module s2p_bank #(parameter int N = 16, parameter int DW = 16) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] widx,
  input  logic [DW-1:0]        wd,
  output logic [N*DW-1:0]      rd
);
  always_ff @(posedge clk)
    if (rst) rd <= '0;
    else if (we) rd[widx*DW +: DW] <= wd;
endmodule

// File: rtl/fir_s2p_buffer.sv
// fir_s2p_buffer: ping-pong serial-to-parallel buffer between the FIR and FFT stages
module fir_s2p_buffer import fir_s2p_buffer_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF,
  parameter int BLOCKS = BLOCKS_DEF
) (
  input logic clk,
  input logic rst,
  fir_s2p_buffer_if.slave io
);
  localparam int IW = $clog2(N);
  localparam int BW = $clog2(BLOCKS);
  logic [1:0] full;
  logic wb, rb, ovf, fd;
  logic [IW-1:0] widx;
  logic [BW-1:0] bcnt;
  logic [N*DW-1:0] rd [2];
  logic acc, last, hs, bend;
  // full flags are sampled pre-edge, so a bank released this cycle cannot take a write yet
  always_comb begin
    acc = io.fir_valid && !full[wb];
    last = acc && widx == IW'(N - 1);
    hs = full[rb] && io.blk_ready;
    bend = bcnt == BW'(BLOCKS - 1);
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    s2p_bank #(.N(N), .DW(DW)) u_bank (
      .clk(clk), .rst(rst), .we(acc && wb == 1'(b)), .widx(widx), .wd(io.fir_d), .rd(rd[b])
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      widx <= '0;
      bcnt <= '0;
      ovf <= 1'b0;
      fd <= 1'b0;
    end else begin
      widx <= acc ? widx + 1'b1 : widx;
      wb <= wb ^ last;
      rb <= rb ^ hs;
      full <= (full | (2'(last) << wb)) & ~(2'(hs) << rb);
      ovf <= ovf | (io.fir_valid && full[wb]);
      bcnt <= hs ? (bend ? '0 : bcnt + 1'b1) : bcnt;
      fd <= hs && bend;
    end
  assign io.blk_valid = full[rb];
  assign io.blk_d = rd[rb];
  assign io.frame_done = fd;
  assign io.overflow = ovf;
endmodule

// File: tb/tb_fir_s2p_buffer.sv
// tb_fir_s2p_buffer: table vectors plus block scoreboard for the ping-pong serial-to-parallel buffer
module tb_fir_s2p_buffer;
  typedef logic [255:0] blk_t;
  typedef struct {
    logic v;
    logic [15:0] d;
    logic rdy;
    logic ebv;
    logic eov;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  int handoffs = 0;
  blk_t q[$];
  int fd_at[$];
  vec_t tbl[34];
  fir_s2p_buffer_if #(.N(16), .DW(16)) bus ();
  fir_s2p_buffer #(.N(16), .DW(16), .BLOCKS(64)) dut (.clk(clk), .rst(rst), .io(bus.slave));
  always #5 clk = ~clk;
  function automatic blk_t mk(int base);
    blk_t b = '0;
    for (int k = 0; k < 16; k++) b[k*16 +: 16] = 16'(base + k);
    return b;
  endfunction
  task automatic chk(string nm, blk_t act, blk_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // inputs are set at the negedge; a handoff seen here completes on the following posedge
  task automatic tick();
    logic hs;
    blk_t snap, exp;
    hs = bus.blk_valid && bus.blk_ready && !rst;
    snap = bus.blk_d;
    @(posedge clk);
    @(negedge clk);
    if (hs) begin
      handoffs++;
      if (q.size() == 0) chk("unexpected_block", snap, '1);
      else begin
        exp = q.pop_front();
        chk("block_data", snap, exp);
      end
    end
    if (bus.frame_done) fd_at.push_back(handoffs);
  endtask
  task automatic send(logic [15:0] d);
    bus.fir_valid = 1'b1;
    bus.fir_d = d;
    tick();
    bus.fir_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.fir_valid = 1'b0;
    tick();
    tick();
    chk("rst_blk_valid", bus.blk_valid, 0);
    chk("rst_blk_d", bus.blk_d, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    rst = 1'b0;
    q.delete();
  endtask
  initial begin
    for (int i = 0; i < 34; i++)
      tbl[i] = '{v: i < 33, d: 16'(i + 1), rdy: 1'b0, ebv: i >= 15, eov: i >= 32};
    bus.fir_valid = 1'b0;
    bus.fir_d = '0;
    bus.blk_ready = 1'b0;
    do_reset();
    // single block, ready held high
    bus.blk_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) q.push_back(mk(1));
      send(16'(i));
      chk("single_bv", bus.blk_valid, i == 16);
    end
    chk("single_blk_d", bus.blk_d, mk(1));
    tick();
    chk("single_bv_after", bus.blk_valid, 0);
    chk("single_ovf", bus.overflow, 0);
    // gapped input
    for (int c = 0; c < 32; c++) begin
      bus.fir_valid = c % 2 == 0;
      bus.fir_d = 16'(200 + c / 2);
      if (c == 30) q.push_back(mk(200));
      tick();
      chk("gap_bv", bus.blk_valid, c == 30);
    end
    bus.fir_valid = 1'b0;
    chk("gap_pending", blk_t'(q.size()), 0);
    chk("gap_ovf", bus.overflow, 0);
    // backpressure table: both banks fill, sample 33 dropped
    for (int i = 0; i < 34; i++) begin
      bus.fir_valid = tbl[i].v;
      bus.fir_d = tbl[i].d;
      bus.blk_ready = tbl[i].rdy;
      if (i == 15) q.push_back(mk(1));
      if (i == 31) q.push_back(mk(17));
      tick();
      chk("bp_bv", bus.blk_valid, tbl[i].ebv);
      chk("bp_ovf", bus.overflow, tbl[i].eov);
      if (tbl[i].ebv) chk("bp_hold", bus.blk_d, mk(1));
    end
    bus.fir_valid = 1'b0;
    bus.blk_ready = 1'b1;
    repeat (3) tick();
    chk("bp_pending", blk_t'(q.size()), 0);
    chk("bp_ovf_sticky", bus.overflow, 1);
    do_reset();
    // reset mid-block discards the partial block
    for (int i = 0; i < 7; i++) send(16'(50 + i));
    rst = 1'b1;
    bus.fir_valid = 1'b1;
    bus.fir_d = 16'h7777;
    tick();
    chk("midrst_bv", bus.blk_valid, 0);
    rst = 1'b0;
    bus.fir_valid = 1'b0;
    for (int i = 100; i <= 115; i++) begin
      if (i == 115) q.push_back(mk(100));
      send(16'(i));
    end
    repeat (2) tick();
    chk("midrst_pending", blk_t'(q.size()), 0);
    do_reset();
    // bank B completes on the edge that hands off bank A
    bus.blk_ready = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      if (i == 16) q.push_back(mk(1));
      send(16'(i));
    end
    chk("sim_bv_a", bus.blk_valid, 1);
    chk("sim_blk_a", bus.blk_d, mk(1));
    bus.blk_ready = 1'b1;
    q.push_back(mk(17));
    send(16'd32);
    chk("sim_bv_b", bus.blk_valid, 1);
    chk("sim_blk_b", bus.blk_d, mk(17));
    tick();
    chk("sim_pending", blk_t'(q.size()), 0);
    do_reset();
    // two full frames back to back
    handoffs = 0;
    fd_at.delete();
    bus.blk_ready = 1'b1;
    bus.fir_valid = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      bus.fir_d = 16'(i);
      if (i % 16 == 15) q.push_back(mk(i - 15));
      tick();
    end
    bus.fir_valid = 1'b0;
    repeat (2) tick();
    chk("frame_handoffs", blk_t'(handoffs), 128);
    chk("frame_pulses", blk_t'(fd_at.size()), 2);
    if (fd_at.size() == 2) begin
      chk("frame_pulse1_at", blk_t'(fd_at[0]), 64);
      chk("frame_pulse2_at", blk_t'(fd_at[1]), 128);
    end
    chk("frame_ovf", bus.overflow, 0);
    chk("frame_pending", blk_t'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_s2p_buffer.md
FIR_S2P_BUFFER -- requirements
Module: fir_s2p_buffer

Interface
REQ-001 SHALL have parameter N, 16, samples per block, a power of two.
REQ-002 SHALL have parameter DW, 16, sample width in bits, two's complement.
REQ-003 SHALL have parameter BLOCKS, 64, blocks per frame.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port fir_d, input, DW bits: signed filtered sample from the upstream FIR.
REQ-008 SHALL have port fir_valid, input, 1 bit: fir_d is valid this cycle; there is no backpressure upstream.
REQ-009 SHALL have port blk_d, output, N*DW bits: parallel block; sample k is in bits [DW*k+DW-1 : DW*k], and k=0 is the oldest.
REQ-010 SHALL have port blk_valid, output, 1 bit: blk_d holds a complete block.
REQ-011 SHALL have port blk_ready, input, 1 bit: downstream (FFT) accepts the block when blk_valid && blk_ready.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse on acceptance of the BLOCKS-th block.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag; a sample was dropped.

Function
REQ-014 SHALL buffer samples in two ping-pong banks (A, B) of N x DW registers, each with a full flag.
REQ-015 SHALL keep a write bank pointer wb, a write index widx (log2 N bits), and a read bank pointer rb.
REQ-016 SHALL treat a sample as accepted when fir_valid=1 and full[wb]=0 at the start of the cycle: bank[wb][widx] <= fir_d, then widx increments.
REQ-017 SHALL, when the accepted sample has widx=N-1, set full[wb], toggle wb and wrap widx to 0.
REQ-018 SHALL, when fir_valid=1 and full[wb]=1, drop the sample, leave widx unchanged and set overflow; overflow clears only on rst.
REQ-019 SHALL drive blk_valid = full[rb] and blk_d = bank[rb], both registered with no combinational path from inputs.
REQ-020 SHALL give a latency of one cycle: blk_valid rises in the cycle after the edge that writes the N-th sample.
REQ-021 SHALL hold blk_d and blk_valid stable while blk_valid=1 and blk_ready=0.
REQ-022 SHALL, on blk_valid && blk_ready, clear full[rb], toggle rb and increment the block counter (log2 BLOCKS bits).
REQ-023 SHALL pulse frame_done in the cycle after the acceptance at which the block counter = BLOCKS-1, with the counter then wrapping to 0.
REQ-024 SHALL evaluate full flags on values at the start of the cycle: a bank released in a cycle does not accept a write in that same cycle; that sample is dropped per REQ-018.
REQ-025 SHALL allow a write completing one bank and a handoff of the other bank in the same cycle; both take effect.
REQ-026 SHALL have no effect from blk_ready while blk_valid=0.
REQ-027 SHALL need no FSM beyond the two full flags; the bank state per bank is EMPTY -> FILLING (widx>0) -> FULL -> EMPTY.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear full[A], full[B], wb, rb, widx, block counter, overflow and frame_done; blk_valid=0 and blk_d=0 in the next cycle.
REQ-029 SHALL, on reset mid-block, discard any partial block; the first accepted sample after reset lands in bank A index 0.
REQ-030 SHALL, while rst=1, accept no samples and signal no handoffs.

Structure
REQ-031 SHALL place N, DW, BLOCKS defaults and log2 widths in the shared DSP package used by the FIR and FFT stages.
REQ-032 SHALL use one sub-module, s2p_bank (N x DW register file with write enable, write index and flat read bus), instantiated twice.
REQ-033 SHALL reuse the existing counter module for the block counter where its keep/clear semantics fit.

Verification
REQ-034 SHALL cover single block: 16 valid samples 1..16 with blk_ready=1 -> blk_valid one cycle after sample 16, blk_d k-th slot = k+1, overflow=0.
REQ-035 SHALL cover backpressure: blk_ready=0 while 32 samples stream -> both banks full; sample 33 dropped, overflow=1; blk_d unchanged across the stall.
REQ-036 SHALL cover gaps: fir_valid toggled 1/0 over 32 cycles -> one block of 16 samples in order; no drops.
REQ-037 SHALL cover frame: 1024 continuous samples, blk_ready=1 -> 64 handoffs; frame_done pulses exactly once after handoff 64; counter returns to 0.
REQ-038 SHALL cover reset mid-block: rst after 7 samples, then samples 100..115 -> one block holding 100..115; no residue from before reset.
REQ-039 SHALL cover simultaneous events: bank B completes on the same edge that bank A is accepted -> next cycle blk_valid=1 with bank B data, no glitch to 0.
